// File: rtl/l2_per_rr_arbiter.sv
// Round-robin share of the L2 peripheral bridge port among N_MASTER demux ports, with in-order response routing.
// Zero-latency request/grant pass-through; a stalled winner stays locked, and issue stops once MAX_OUTST transactions are in flight.
module l2_per_rr_arbiter #(
    parameter int N_MASTER   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int AUX_WIDTH  = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_MASTER-1:0]                  m_req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  m_add_i,
    input  logic [N_MASTER-1:0]                  m_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  m_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    m_be_i,
    input  logic [N_MASTER-1:0][AUX_WIDTH-1:0]   m_aux_i,
    output logic [N_MASTER-1:0]                  m_gnt_o,
    output logic [N_MASTER-1:0]                  m_r_valid_o,
    output logic [DATA_WIDTH-1:0]                m_r_rdata_o,
    output logic                                 m_r_opc_o,
    output logic [AUX_WIDTH-1:0]                 m_r_aux_o,
    output logic                                 s_req_o,
    output logic [ADDR_WIDTH-1:0]                s_add_o,
    output logic                                 s_wen_o,
    output logic [DATA_WIDTH-1:0]                s_wdata_o,
    output logic [BE_WIDTH-1:0]                  s_be_o,
    output logic [AUX_WIDTH-1:0]                 s_aux_o,
    input  logic                                 s_gnt_i,
    input  logic                                 s_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                s_r_rdata_i,
    input  logic                                 s_r_opc_i,
    input  logic [AUX_WIDTH-1:0]                 s_r_aux_i,
    output logic [$clog2(MAX_OUTST):0]           outst_cnt_o,
    output logic                                 unexp_rsp_o
);

    localparam int IW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] lock_id;
    logic          lock;
    logic [IW-1:0] rr_win;
    logic [IW-1:0] winner;
    logic          lock_hit;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [IW-1:0] id_fifo [MAX_OUTST];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    always_comb begin
        int  idx;
        logic found;
        rr_win = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_MASTER; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_MASTER) idx = idx - N_MASTER;
            if (!found && m_req_i[idx]) begin
                found  = 1'b1;
                rr_win = IW'(idx);
            end
        end
    end

    // A lock only counts while its owner still requests; otherwise fall back to round-robin.
    assign lock_hit = lock & m_req_i[lock_id];
    assign winner   = lock_hit ? lock_id : rr_win;

    // Full comes from the registered count only, so responses never reach s_req_o combinationally.
    assign full    = (count == CW'(MAX_OUTST));
    assign empty   = (count == '0);
    assign s_req_o = (|m_req_i) & ~full;
    assign push    = s_req_o & s_gnt_i;
    assign pop     = s_r_valid_i & ~empty;

    assign s_add_o   = s_req_o ? m_add_i[winner]   : '0;
    assign s_wen_o   = s_req_o ? m_wen_i[winner]   : 1'b0;
    assign s_wdata_o = s_req_o ? m_wdata_i[winner] : '0;
    assign s_be_o    = s_req_o ? m_be_i[winner]    : '0;
    assign s_aux_o   = s_req_o ? m_aux_i[winner]   : '0;

    always_comb begin
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        if (push) m_gnt_o[winner] = 1'b1;
        if (pop)  m_r_valid_o[id_fifo[rd_ptr]] = 1'b1;
    end

    assign m_r_rdata_o = s_r_rdata_i;
    assign m_r_opc_o   = s_r_opc_i;
    assign m_r_aux_o   = s_r_aux_i;
    assign unexp_rsp_o = s_r_valid_i & empty;
    assign outst_cnt_o = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
        end else if (push) begin
            rr_ptr <= (winner == IW'(N_MASTER - 1)) ? '0 : winner + 1'b1;
            lock   <= 1'b0;
        end else if (s_req_o) begin
            lock    <= 1'b1;
            lock_id <= winner;
        end else if (lock && !m_req_i[lock_id]) begin
            lock <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTST; i++) id_fifo[i] <= '0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
